// File: rtl/imm_gen_pkg.sv
// ============================================================================
// imm_gen_pkg: shared types, opcodes and helpers for the pipelined immediate
// generator.  Rev 1.0
// ============================================================================
`default_nettype none

package imm_gen_pkg;

    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 32;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;

    // Fields are sized for the widest configuration; users slice to XLEN/TAG_W.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// imm_decode: combinational RV32I/RV64I immediate decoder, result at full
// 64-bit sign/zero extension (caller slices to XLEN).  Rev 1.0
// ============================================================================
`default_nettype none

module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] inst_code,
    output imm_entry_t  entry
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       sgn;

    assign opcode = inst_code[6:0];
    assign funct3 = inst_code[14:12];
    assign sgn    = inst_code[31];

    always_comb begin
        entry = '0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                entry.fmt = FMT_I;
                entry.imm = {{52{sgn}}, inst_code[31:20]};
            end
            OPC_OPIMM: begin
                if (is_shift_f3(funct3)) begin
                    entry.fmt = FMT_SH;
                    if (XLEN == 64) entry.imm = {58'd0, inst_code[25:20]};
                    else            entry.imm = {59'd0, inst_code[24:20]};
                end else begin
                    entry.fmt = FMT_I;
                    entry.imm = {{52{sgn}}, inst_code[31:20]};
                end
            end
            OPC_OPIMM32: begin
                // Word-sized ops only exist in RV64; RV32 treats this opcode as unknown.
                if (XLEN == 64) begin
                    if (is_shift_f3(funct3)) begin
                        entry.fmt = FMT_SH;
                        entry.imm = {59'd0, inst_code[24:20]};
                    end else begin
                        entry.fmt = FMT_I;
                        entry.imm = {{52{sgn}}, inst_code[31:20]};
                    end
                end
            end
            OPC_STORE: begin
                entry.fmt = FMT_S;
                entry.imm = {{52{sgn}}, inst_code[31:25], inst_code[11:7]};
            end
            OPC_BRANCH: begin
                entry.fmt = FMT_B;
                entry.imm = {{51{sgn}}, sgn, inst_code[7], inst_code[30:25],
                             inst_code[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                entry.fmt = FMT_U;
                entry.imm = {{32{sgn}}, inst_code[31:12], 12'd0};
            end
            OPC_JAL: begin
                entry.fmt = FMT_J;
                entry.imm = {{43{sgn}}, sgn, inst_code[19:12], inst_code[20],
                             inst_code[30:21], 1'b0};
            end
            default: begin
                entry.fmt = FMT_NONE;
                entry.imm = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// imm_gen_pipe: valid/ready immediate generator with a 2-entry skid buffer so
// in_ready comes straight from a flop.  TAG_W may be 1..32.  Rev 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    buf_state_e state;
    imm_entry_t dec_raw;
    imm_entry_t dec_entry;
    imm_entry_t main_q;
    imm_entry_t skid_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       in_xfer;
    logic       out_xfer;
    logic       unused_bits;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst_code (inst_code),
        .entry     (dec_raw)
    );

    always_comb begin
        dec_entry     = dec_raw;
        dec_entry.tag = TAG_MAX_W'(in_tag);
    end

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q      <= dec_entry;
                        state       <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= dec_entry;
                    end else if (in_xfer) begin
                        skid_q     <= dec_entry;
                        state      <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is already low here, so only the drain path exists.
                    if (out_xfer) begin
                        main_q     <= skid_q;
                        state      <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign imm_out   = main_q.imm[XLEN-1:0];
    assign imm_fmt   = main_q.fmt;
    assign out_tag   = main_q.tag[TAG_W-1:0];

    // Upper imm/tag bits are unused in narrow configurations.
    assign unused_bits = ^{main_q, dec_raw.tag};

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe against an
// arithmetic reference model and a FIFO scoreboard.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_I    = 3'd1;
    localparam logic [2:0] F_S    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_U    = 3'd4;
    localparam logic [2:0] F_J    = 3'd5;
    localparam logic [2:0] F_SH   = 3'd6;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst_code;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [2:0]       imm_fmt;
    logic [TAG_W-1:0] out_tag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    imm_gen_pipe #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_code (inst_code),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out),
        .imm_fmt   (imm_fmt),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Reference: each format assembled from instruction fields with integer arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] w, input logic [TAG_W-1:0] t);
        exp_t   e;
        longint sw;
        longint hi;
        longint v;
        logic [2:0] f;
        sw = longint'($signed(w));
        hi = sw >>> 31;
        v  = 0;
        f  = F_NONE;
        case (w[6:0])
            7'h03, 7'h67: begin
                f = F_I; v = sw >>> 20;
            end
            7'h13: begin
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    f = F_SH; v = (XLEN == 64) ? longint'((w >> 20) & 63) : longint'((w >> 20) & 31);
                end else begin
                    f = F_I; v = sw >>> 20;
                end
            end
            7'h1B: begin
                if (XLEN == 64) begin
                    if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                        f = F_SH; v = longint'((w >> 20) & 31);
                    end else begin
                        f = F_I; v = sw >>> 20;
                    end
                end
            end
            7'h23: begin
                f = F_S; v = sw >>> 25;
                v = (v * 32) + longint'((w >> 7) & 31);
            end
            7'h63: begin
                f = F_B;
                v = hi * 4096 + longint'((w >> 7) & 1) * 2048
                  + longint'((w >> 25) & 63) * 32 + longint'((w >> 8) & 15) * 2;
            end
            7'h37, 7'h17: begin
                f = F_U; v = sw & ~longint'(4095);
            end
            7'h6F: begin
                f = F_J;
                v = hi * 1048576 + longint'((w >> 12) & 255) * 4096
                  + longint'((w >> 20) & 1) * 2048 + longint'((w >> 21) & 1023) * 2;
            end
            default: begin
                f = F_NONE; v = 0;
            end
        endcase
        e.imm = v[XLEN-1:0];
        e.fmt = f;
        e.tag = t;
        return e;
    endfunction

    task automatic one(input string nm, input logic [31:0] w, input logic [TAG_W-1:0] t,
                       input logic [63:0] ei, input logic [2:0] ef);
        @(negedge clk);
        in_valid = 1'b1; inst_code = w; in_tag = t; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_imm"},   64'(imm_out),   ei);
        chk({nm, "_fmt"},   64'(imm_fmt),   64'(ef));
        chk({nm, "_tag"},   64'(out_tag),   64'(t));
    endtask

    initial begin
        logic [6:0] ops [11];
        logic       pending;
        exp_t       e;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33, 7'h73};

        reset = 1'b0; in_valid = 1'b0; inst_code = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_imm",       64'(imm_out),   64'd0);
        chk("rst_fmt",       64'(imm_fmt),   64'(F_NONE));
        chk("rst_tag",       64'(out_tag),   64'd0);
        reset = 1'b1;

        // Directed decode cases, out_ready held high.
        one("beq",  32'h00320463, 8'h11, 64'h0000_0008, F_B);
        one("addi", 32'hFFF00093, 8'h12, 64'hFFFF_FFFF, F_I);
        one("srai", 32'h4030D093, 8'h13, 64'h0000_0003, F_SH);
        one("sw",   32'hFE20AC23, 8'h14, 64'hFFFF_FFF8, F_S);
        one("jal",  32'hFFDFF0EF, 8'h15, 64'hFFFF_FFFC, F_J);
        one("lui",  32'h123450B7, 8'h16, 64'h1234_5000, F_U);
        one("add",  32'h003100B3, 8'h17, 64'h0000_0000, F_NONE);
        @(negedge clk);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: three back-to-back words against a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1; inst_code = 32'h00100093; in_tag = 8'd1;
        @(negedge clk);
        chk("bp_valid1", 64'(out_valid), 64'd1);
        chk("bp_rdy1",   64'(in_ready),  64'd1);
        inst_code = 32'h00200093; in_tag = 8'd2;
        @(negedge clk);
        chk("bp_rdy_full", 64'(in_ready), 64'd0);
        chk("bp_hold_tag", 64'(out_tag),  64'd1);
        inst_code = 32'h00300093; in_tag = 8'd3;
        @(negedge clk);
        chk("bp_rdy_full2", 64'(in_ready), 64'd0);
        chk("bp_hold_tag2", 64'(out_tag),  64'd1);
        chk("bp_hold_imm",  64'(imm_out),  64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_tag2", 64'(out_tag), 64'd2);
        chk("bp_imm2", 64'(imm_out), 64'd2);
        chk("bp_rdy2", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_tag3", 64'(out_tag), 64'd3);
        chk("bp_imm3", 64'(imm_out), 64'd3);
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset while both entries are occupied.
        out_ready = 1'b0; in_valid = 1'b1; inst_code = 32'h00900093; in_tag = 8'd9;
        @(negedge clk);
        in_tag = 8'd10;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rf_full", 64'(in_ready), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("rf_valid", 64'(out_valid), 64'd0);
        chk("rf_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; inst_code = 32'h00B00093; in_tag = 8'd11; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rf_post_valid", 64'(out_valid), 64'd1);
        chk("rf_post_tag",   64'(out_tag),   64'd11);
        @(negedge clk);
        chk("rf_alone", 64'(out_valid), 64'd0);

        // Random stream against the scoreboard.
        pending = 1'b0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            if (!pending) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                inst_code = $urandom;
                if ($urandom_range(0, 7) != 0) inst_code[6:0] = ops[$urandom_range(0, 10)];
                in_tag    = TAG_W'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            chk("rnd_in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
            chk("rnd_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rnd_imm", 64'(imm_out), 64'(e.imm));
                chk("rnd_fmt", 64'(imm_fmt), 64'(e.fmt));
                chk("rnd_tag", 64'(out_tag), 64'(e.tag));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_dec(inst_code, in_tag));
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
        end

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fin_imm", 64'(imm_out), 64'(e.imm));
                chk("fin_tag", 64'(out_tag), 64'(e.tag));
            end
            @(negedge clk);
        end
        chk("fin_left",  64'(exp_q.size()), 64'd0);
        chk("fin_valid", 64'(out_valid),    64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator.
- Decodes every RV32I/RV64I immediate format: I, S, B, U, J, plus shift-amount.
- Sign-extends or zero-extends to XLEN and tags each result with its format code.
- Sits between fetch/decode and the ID/EX register behind a valid/ready handshake, with a 2-entry skid buffer so in_ready is a registered signal.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
TAG_W, 8, width of the opaque tag (instruction id) carried alongside each instruction.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  inst_code and in_tag are valid
in_ready  output  1  block can accept; driven directly from a flop
inst_code  input  32  instruction word
in_tag  input  TAG_W  tag passed through unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
imm_out  output  XLEN  generated immediate
imm_fmt  output  3  format code (imm_fmt_e)
out_tag  output  TAG_W  tag belonging to imm_out

Behaviour:
- Reset (reset=0, asynchronous): buffer EMPTY, out_valid=0, in_ready=1, imm_out=0, imm_fmt=FMT_NONE, out_tag=0. Any in-flight entries are discarded.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Decode (combinational, pre-buffer), selected by opcode inst_code[6:0]:
  - 0000011 load, 1100111 JALR → FMT_I. Value = sext(inst[31:20]).
  - 0010011 OP-IMM:
    - funct3 001 or 101 → FMT_SH. Value = zext(inst[20+SHAMT_W-1:20]); SHAMT_W is 5 for XLEN=32, 6 for XLEN=64. Bit 30 (SRAI) is ignored.
    - Otherwise → FMT_I.
  - 0011011 OP-IMM-32, only when XLEN=64:
    - funct3 001 or 101 → FMT_SH with a 5-bit shamt.
    - Otherwise → FMT_I.
    - When XLEN=32 this opcode is FMT_NONE.
  - 0100011 store → FMT_S. Value = sext({inst[31:25], inst[11:7]}).
  - 1100011 branch → FMT_B. Value = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 0110111 LUI, 0010111 AUIPC → FMT_U. Value = sext({inst[31:12], 12'b0}); bits 63:32 are sign-filled when XLEN=64.
  - 1101111 JAL → FMT_J. Value = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Any other opcode → FMT_NONE, value 0. This includes R-type and SYSTEM; it is not an error.
- Buffer FSM (states EMPTY, ONE, FULL), main register plus skid register:
  - EMPTY: input transfer → ONE.
  - ONE:
    - Input only → FULL; the new entry goes to the skid register.
    - Output only → EMPTY.
    - Both input and output → stay in ONE; the main register loads the new entry.
  - FULL:
    - Output transfer → ONE; skid moves to main. in_ready is already 0, so no input is accepted.
  - in_ready = (state != FULL), registered. out_valid = (state != EMPTY).
- Latency: 1 cycle from input transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- Outputs are held stable while out_valid & !out_ready.
- Order is strictly FIFO.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Registered outputs change only on an output transfer or on a load into an empty/ONE main register.
- Reset asserted mid-operation flushes both entries in the same cycle. No output transfer is reported for the flushed entries.

Decomposition:
- Package imm_gen_pkg holds:
  - imm_fmt_e enum: FMT_NONE=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH.
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR.
  - Struct imm_entry_t {imm, fmt, tag}.
- Sub-module imm_decode (combinational, parametrised by XLEN) produces imm_entry_t. imm_gen_pipe holds only the FSM and the two registers.

Test Plan:
- beq x4,x3,8 (0x00320463), out_ready=1 → next cycle imm_out=0x00000008, imm_fmt=FMT_B, tag echoed.
- addi x1,x0,-1 (0xFFF00093) → 0xFFFFFFFF (XLEN=32), 0xFFFFFFFFFFFFFFFF (XLEN=64), FMT_I. srai x1,x1,3 (0x4030D093) → 0x3, FMT_SH.
- sw x2,-8(x1) (0xFE20AC23) → 0xFFFFFFF8, FMT_S. jal ra,-4 (0xFFDFF0EF) → 0xFFFFFFFC, FMT_J. lui x1,0x12345 (0x123450B7) → 0x12345000, FMT_U. add (0x003100B3) → 0, FMT_NONE.
- Backpressure: out_ready=0, drive 3 back-to-back instructions with tags 1,2,3 → tags 1 and 2 accepted, in_ready=0 from the cycle after the 2nd. Raise out_ready → outputs appear in order 1,2,3 on consecutive cycles, values unchanged while stalled.
- Reset while FULL → out_valid=0, in_ready=1 asynchronously. The next instruction after reset release appears alone 1 cycle later.
- Random stream of 10k legal/illegal words with random out_ready, compared against a reference model → no loss, duplication or reordering; in_ready never 0 in EMPTY/ONE.
